// File: rtl/ahb_lite_uart_loader.sv
// AHB-Lite single master that configures a UART16550 slave and loads a length-framed payload.
// Define UART_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte after the payload.
module ahb_lite_uart_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [15:0] DIVISOR   = 16'd27,
    parameter logic [31:0] MAX_LEN   = 32'h0001_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic [31:0] word_data,
    output logic [29:0] word_index,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        StIdle, StCfg, StPoll, StRxRead, StHdr, StPay, StEmit, StChk, StDone, StError
    } state_e;

    localparam logic [2:0] RegRbr = 3'd0;
    localparam logic [2:0] RegDll = 3'd0;
    localparam logic [2:0] RegDlm = 3'd1;
    localparam logic [2:0] RegFcr = 3'd2;
    localparam logic [2:0] RegLcr = 3'd3;
    localparam logic [2:0] RegLsr = 3'd5;

    state_e      state_q, state_d;
    logic        dphase_q, dphase_d;
    logic [2:0]  cfg_idx_q, cfg_idx_d;
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  sum_q, sum_d;
    logic [31:0] len_q, len_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [29:0] index_q, index_d;
    logic        busy_q, busy_d, done_q, done_d, error_q, error_d;

    logic [2:0]  reg_sel;
    logic [7:0]  wr_byte;
    logic [31:0] len_new;
    logic        xfer_ok, chk_ok;
    logic        unused_hrdata;

    assign unused_hrdata = ^HRDATA[31:8];

`ifdef UART_LOADER_CHECKSUM_EN
    localparam state_e StTail = StPoll;  // one more byte (the checksum) follows the payload
    assign chk_ok = (byte_q == sum_q);
`else
    localparam state_e StTail = StDone;
    logic unused_sum;
    assign chk_ok     = 1'b1;
    assign unused_sum = ^sum_q;
`endif

    assign HBURST     = 3'b000;
    assign HMASTLOCK  = 1'b0;
    assign HPROT      = 4'b0011;
    assign HSIZE      = 3'b010;
    assign word_valid = (state_q == StEmit);
    assign word_data  = word_q;
    assign word_index = index_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign len_new    = {byte_q, len_q[31:8]};

    always_comb begin
        reg_sel = RegRbr;
        wr_byte = 8'h00;
        if (state_q == StCfg) begin
            case (cfg_idx_q)
                3'd0:    begin reg_sel = RegLcr; wr_byte = 8'h83;         end
                3'd1:    begin reg_sel = RegDll; wr_byte = DIVISOR[7:0];  end
                3'd2:    begin reg_sel = RegDlm; wr_byte = DIVISOR[15:8]; end
                3'd3:    begin reg_sel = RegLcr; wr_byte = 8'h03;         end
                default: begin reg_sel = RegFcr; wr_byte = 8'h07;         end
            endcase
        end else if (state_q == StPoll) begin
            reg_sel = RegLsr;
        end
    end

    always_comb begin
        state_d   = state_q;
        dphase_d  = dphase_q;
        cfg_idx_d = cfg_idx_q;
        hdr_cnt_d = hdr_cnt_q;
        byte_d    = byte_q;
        sum_d     = sum_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        index_d   = index_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        HTRANS    = 2'b00;
        HADDR     = 32'h0;
        HWRITE    = 1'b0;
        HWDATA    = 32'h0;
        xfer_ok   = 1'b0;

        // One transfer at a time: address phase, then data phase until HREADY.
        if (state_q == StCfg || state_q == StPoll || state_q == StRxRead) begin
            if (!dphase_q) begin
                if (HREADY) begin
                    HTRANS   = 2'b10;
                    HADDR    = BASE_ADDR + {27'b0, reg_sel, 2'b00};
                    HWRITE   = (state_q == StCfg);
                    dphase_d = 1'b1;
                end
            end else begin
                if (state_q == StCfg) HWDATA = {24'b0, wr_byte};
                if (HREADY) begin
                    dphase_d = 1'b0;
                    if (HRESP) state_d = StError;
                    else       xfer_ok = 1'b1;
                end
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StCfg;
                    dphase_d  = 1'b0;
                    cfg_idx_d = 3'd0;
                    hdr_cnt_d = 3'd0;
                    sum_d     = 8'h00;
                    len_d     = 32'h0;
                    cnt_d     = 32'h0;
                    word_d    = 32'h0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                end
            end
            StCfg: begin
                if (xfer_ok) begin
                    if (cfg_idx_q == 3'd4) state_d = StPoll;
                    else                   cfg_idx_d = cfg_idx_q + 3'd1;
                end
            end
            StPoll: begin
                if (xfer_ok) begin
                    if (|HRDATA[4:1])   state_d = StError;
                    else if (HRDATA[0]) state_d = StRxRead;
                end
            end
            StRxRead: begin
                if (xfer_ok) begin
                    byte_d = HRDATA[7:0];
                    if (hdr_cnt_q != 3'd4)  state_d = StHdr;
                    else if (cnt_q != len_q) state_d = StPay;
                    else                     state_d = StChk;
                end
            end
            StHdr: begin
                len_d     = len_new;
                hdr_cnt_d = hdr_cnt_q + 3'd1;
                state_d   = StPoll;
                if (hdr_cnt_q == 3'd3) begin
                    if (len_new > MAX_LEN)   state_d = StError;
                    else if (len_new == 0)   state_d = StTail;
                end
            end
            StPay: begin
                word_d[{cnt_q[1:0], 3'b000} +: 8] = byte_q;
                cnt_d   = cnt_q + 32'd1;
                sum_d   = sum_q + byte_q;
                index_d = cnt_q[31:2];
                if (cnt_q[1:0] == 2'd3 || cnt_q + 32'd1 == len_q) state_d = StEmit;
                else                                            state_d = StPoll;
            end
            StEmit: begin
                if (word_ready) begin
                    word_d  = 32'h0;
                    state_d = (cnt_q == len_q) ? StTail : StPoll;
                end
            end
            StChk:   state_d = chk_ok ? StDone : StError;
            StDone: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            StError: begin
                busy_d  = 1'b0;
                error_d = 1'b1;
                word_d  = 32'h0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= StIdle;
            dphase_q  <= 1'b0;
            cfg_idx_q <= 3'd0;
            hdr_cnt_q <= 3'd0;
            byte_q    <= 8'h00;
            sum_q     <= 8'h00;
            len_q     <= 32'h0;
            cnt_q     <= 32'h0;
            word_q    <= 32'h0;
            index_q   <= 30'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dphase_q  <= dphase_d;
            cfg_idx_q <= cfg_idx_d;
            hdr_cnt_q <= hdr_cnt_d;
            byte_q    <= byte_d;
            sum_q     <= sum_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            index_q   <= index_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

endmodule

// File: tb/tb_ahb_lite_uart_loader.sv
// Bench for ahb_lite_uart_loader: behavioural UART slave, frame vector table, word scoreboard.
module tb_ahb_lite_uart_loader;

    localparam logic [31:0] Base = 32'h0000_0000;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;
    logic        start   = 1'b0;
    logic [31:0] HADDR, HWDATA, word_data;
    logic [31:0] HRDATA  = 32'h0;
    logic        HREADY  = 1'b1;
    logic        HRESP   = 1'b0;
    logic [2:0]  HBURST, HSIZE;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK, HWRITE, word_valid, busy, done, error;
    logic [29:0] word_index;
    logic        word_ready = 1'b1;

    ahb_lite_uart_loader dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .word_data(word_data), .word_index(word_index), .word_valid(word_valid),
        .word_ready(word_ready), .busy(busy), .done(done), .error(error)
    );

    always #5 HCLK = ~HCLK;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // UART slave model state
    logic [7:0]  rxq[$];
    logic [61:0] exp_q[$];
    bit          lsr_force_en = 1'b0;
    logic [7:0]  lsr_force    = 8'h00;
    bit          resp_force   = 1'b0;
    bit          ap_valid = 1'b0, ap_write = 1'b0;
    logic [31:0] ap_addr  = 32'h0, dp_addr = 32'h0;
    bit          dp_write = 1'b0, dp_wait = 1'b0;
    int          wr_idx = 0;
    int          nonseq_cnt = 0;

    logic [31:0] cfg_addr_tbl [5] = '{Base + 32'hC, Base, Base + 32'h4, Base + 32'hC, Base + 32'h8};
    logic [31:0] cfg_data_tbl [5] = '{32'h83, 32'h1B, 32'h00, 32'h03, 32'h07};

    // Mid-cycle monitor: address phases, write data, word handshakes.
    initial forever begin
        @(negedge HCLK);
        if (HTRANS == 2'b10) nonseq_cnt++;
        ap_valid = HRESETn && (HTRANS == 2'b10) && HREADY;
        ap_write = HWRITE;
        ap_addr  = HADDR;
        if (HRESETn && dp_write && !HREADY) chk("wait_state_htrans", 64'(HTRANS), 64'd0);
        if (HRESETn && dp_write && HREADY) begin
            if (wr_idx < 5) begin
                chk($sformatf("cfg_addr%0d", wr_idx), 64'(dp_addr), 64'(cfg_addr_tbl[wr_idx]));
                chk($sformatf("cfg_data%0d", wr_idx), 64'(HWDATA), 64'(cfg_data_tbl[wr_idx]));
            end
            wr_idx++;
        end
        if (HRESETn && word_valid && word_ready) begin
            if (exp_q.size() == 0) chk("unexpected_word", 64'(exp_q.size()), 64'd1);
            else chk("word", 64'({word_data, word_index}), 64'(exp_q.pop_front()));
        end
    end

    // Slave response for the cycle that starts now; writes take one wait state.
    initial forever begin
        @(posedge HCLK);
        #1;
        if (!HRESETn) begin
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0; dp_write = 1'b0; dp_wait = 1'b0;
        end else if (ap_valid && ap_write) begin
            HREADY = 1'b0; HRESP = 1'b0; dp_write = 1'b1; dp_wait = 1'b1; dp_addr = ap_addr;
        end else if (dp_wait) begin
            HREADY = 1'b1; dp_wait = 1'b0;
        end else if (ap_valid) begin
            dp_write = 1'b0; HREADY = 1'b1; HRESP = resp_force; resp_force = 1'b0;
            if (ap_addr == Base + 32'h14)
                HRDATA = lsr_force_en ? {24'h0, lsr_force} : ((rxq.size() > 0) ? 32'h01 : 32'h00);
            else if (ap_addr == Base && rxq.size() > 0)
                HRDATA = {24'h0, rxq.pop_front()};
            else
                HRDATA = 32'h0;
        end else begin
            dp_write = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        end
        ap_valid = 1'b0;
    end

    typedef struct {
        logic [31:0] len;
        int          npay;
        logic [63:0] pay;
        bit          corrupt;
        bit          len_err;
        int          stall;
    } vec_t;

    vec_t vecs[8];

    task automatic check_idle(input string tag);
        chk({tag, "_bus"}, 64'({HTRANS, HWRITE, HADDR}), 64'd0);
        chk({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
        chk({tag, "_const"}, 64'({HBURST, HMASTLOCK, HPROT, HSIZE}), 64'({3'b000, 1'b0, 4'b0011, 3'b010}));
        chk({tag, "_stream"}, 64'({word_valid, word_data, word_index}), 64'd0);
        chk({tag, "_status"}, 64'({busy, done, error}), 64'd0);
    endtask

    task automatic pulse_start();
        @(posedge HCLK);
        #1;
        start  = 1'b1;
        wr_idx = 0;
        @(posedge HCLK);
        #1;
        start = 1'b0;
    endtask

    task automatic load_frame(input vec_t v);
        logic [7:0] sum;
        sum = 8'h00;
        rxq.delete();
        for (int i = 0; i < 4; i++) rxq.push_back(v.len[8*i +: 8]);
        for (int i = 0; i < v.npay; i++) begin
            rxq.push_back(v.pay[8*i +: 8]);
            sum = sum + v.pay[8*i +: 8];
        end
        if (ChkEn && !v.len_err) rxq.push_back(v.corrupt ? 8'h00 : sum);
    endtask

    task automatic run_vec(input vec_t v, input string tag, input bit force_err);
        logic [31:0] w;
        logic [61:0] d0;
        bit          exp_err, stable;
        int          n, n0;
        exp_q.delete();
        load_frame(v);
        exp_err = v.len_err || force_err || (ChkEn && v.corrupt);
        if (!v.len_err && !force_err) begin
            for (int i = 0; i < v.npay; i += 4) begin
                w = 32'h0;
                for (int j = 0; j < 4; j++)
                    if (i + j < v.npay) w[8*j +: 8] = v.pay[8*(i+j) +: 8];
                exp_q.push_back({w, 30'(i / 4)});
            end
        end
        word_ready = (v.stall == 0);
        pulse_start();
        if (v.stall > 0) begin
            n = 0;
            while (!word_valid && n < 4000) begin @(negedge HCLK); n++; end
            chk({tag, "_stall_valid"}, 64'(word_valid), 64'd1);
            d0 = {word_data, word_index};
            n0 = nonseq_cnt;
            stable = 1'b1;
            for (int k = 0; k < v.stall; k++) begin
                @(posedge HCLK);
                #1;
                start = (k == 5);  // ignored while busy
                @(negedge HCLK);
                if (!word_valid || {word_data, word_index} !== d0) stable = 1'b0;
            end
            start = 1'b0;
            chk({tag, "_stall_stable"}, 64'(stable), 64'd1);
            chk({tag, "_stall_nonseq"}, 64'(nonseq_cnt - n0), 64'd0);
            @(posedge HCLK);
            #1;
            word_ready = 1'b1;
        end
        n = 0;
        while (!(done || error) && n < 4000) begin @(negedge HCLK); n++; end
        chk({tag, "_finished"}, 64'(done | error), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'(!exp_err));
        chk({tag, "_error"}, 64'(error), 64'(exp_err));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_cfg_writes"}, 64'(wr_idx), 64'd5);
        if (!force_err) chk({tag, "_rx_left"}, 64'(rxq.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{32'd5, 5, 64'h0000_0055_4433_2211, 1'b0, 1'b0, 0};
        vecs[1] = '{32'd4, 4, 64'h0000_0000_0403_0201, 1'b0, 1'b0, 0};
        vecs[2] = '{32'd1, 1, 64'h0000_0000_0000_00A5, 1'b0, 1'b0, 0};
        vecs[3] = '{32'd0, 0, 64'h0, 1'b0, 1'b0, 0};
        vecs[4] = '{32'h0001_0001, 0, 64'h0, 1'b0, 1'b1, 0};
        vecs[5] = '{32'd8, 8, 64'hF0E0_D0C0_B0A0_9080, 1'b0, 1'b0, 0};
        vecs[6] = '{32'd3, 3, 64'h0000_0000_00CC_BBAA, 1'b0, 1'b0, 20};
        vecs[7] = '{32'd2, 2, 64'h0000_0000_0000_BBAA, 1'b1, 1'b0, 0};

        #2;
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        check_idle("reset");
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);

        lsr_force_en = 1'b1;
        lsr_force    = 8'h03;
        run_vec(vecs[0], "overrun", 1'b1);
        lsr_force_en = 1'b0;

        resp_force = 1'b1;
        run_vec(vecs[0], "hresp", 1'b1);
        resp_force = 1'b0;

        // Asynchronous reset while payload bytes are being gathered.
        exp_q.delete();
        load_frame(vecs[5]);
        word_ready = 1'b1;
        pulse_start();
        n = 0;
        while (rxq.size() > (ChkEn ? 7 : 6) && n < 4000) begin @(negedge HCLK); n++; end
        chk("midpay_reached", 64'(rxq.size() <= (ChkEn ? 7 : 6)), 64'd1);
        @(posedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        check_idle("async_reset");
        repeat (2) @(negedge HCLK);
        rxq.delete();
        exp_q.delete();
        HRESETn = 1'b1;
        run_vec(vecs[0], "after_reset", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
